// File: rtl/sad_pkg.sv
// Shared types and width helpers for the sum-of-absolute-differences accumulator.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } sad_state_e;

  function automatic int unsigned acc_width(input int unsigned width, input int unsigned count);
    return width + $clog2(count);
  endfunction

endpackage

// File: rtl/abs_diff_core.sv
// Combinational compare/subtract core: gt is a>b under the selected mode,
// mag is a-b truncated to WIDTH (the caller negates it when a<=b).
module abs_diff_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             gt,
  output logic [WIDTH-1:0] mag
);

  always_comb begin
    gt  = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
    mag = a + ~b + WIDTH'(1);
  end

endmodule

// File: rtl/sad_accumulator.sv
// Multi-cycle |A-B| accumulator: one sample every 3 cycles, sum held until consumed.
module sad_accumulator
  import sad_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned COUNT = 4,
  localparam int unsigned ACC_W = acc_width(WIDTH, COUNT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             signed_mode,
  output logic             diff_valid,
  output logic [WIDTH-1:0] Diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] Sum
);

  localparam int unsigned IDX_W = (COUNT > 2) ? $clog2(COUNT) : 1;

  sad_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mode_q, mode_d;
  logic             gt_q, gt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             dv_q, dv_d;

  logic             core_gt;
  logic [WIDTH-1:0] core_mag;

  abs_diff_core #(.WIDTH(WIDTH)) u_core (
    .a           (a_q),
    .b           (b_q),
    .signed_mode (mode_q),
    .gt          (core_gt),
    .mag         (core_mag)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    gt_d    = gt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = Ain;
          b_d = Bin;
          if (idx_q == '0) mode_d = signed_mode;
          state_d = CMP;
        end
      end
      CMP: begin
        gt_d    = core_gt;
        state_d = SUB;
      end
      SUB: begin
        // core_mag is A-B; negating it yields B-A modulo 2^WIDTH
        diff_d  = gt_q ? core_mag : (~core_mag + WIDTH'(1));
        dv_d    = 1'b1;
        acc_d   = acc_q + ACC_W'(diff_d);
        idx_d   = idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(COUNT - 1)) ? DONE : IDLE;
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      gt_q    <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      gt_q    <= gt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      dv_q    <= dv_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign Sum        = acc_q;
  assign Diff       = diff_q;
  assign diff_valid = dv_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// Directed table and corner-case bench for sad_accumulator at WIDTH=8, COUNT=4.
module tb_sad_accumulator;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Ain, Bin;
  logic       signed_mode;
  logic       diff_valid;
  logic [7:0] Diff;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] Sum;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  sad_accumulator #(.WIDTH(8), .COUNT(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Ain         (Ain),
    .Bin         (Bin),
    .signed_mode (signed_mode),
    .diff_valid  (diff_valid),
    .Diff        (Diff),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Sum         (Sum)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] d;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_abs(input logic [7:0] a, input logic [7:0] b, input logic m);
    int x, y, d;
    x = m ? int'($signed(a)) : int'(a);
    y = m ? int'($signed(b)) : int'(b);
    d = x - y;
    if (d < 0) d = -d;
    return d[7:0];
  endfunction

  // Offers one sample, keeps in_valid high with junk during CMP/SUB, checks Diff.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic [7:0] exp, output int acc_cyc);
    int w;
    w = 0;
    in_valid = 1'b1; Ain = a; Bin = b; signed_mode = m;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
      in_valid = 1'b0;
      acc_cyc = cyc;
      return;
    end
    acc_cyc = cyc;
    tick();
    Ain = 8'($urandom); Bin = 8'($urandom); signed_mode = 1'($urandom);
    chk("in_ready_cmp", 32'(in_ready), 32'd0);
    chk("diff_valid_cmp", 32'(diff_valid), 32'd0);
    tick();
    tick();
    in_valid = 1'b0;
    chk("diff_valid", 32'(diff_valid), 32'd1);
    chk("diff", 32'(Diff), 32'(exp));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("sum_cleared", 32'(Sum), 32'd0);
  endtask

  initial begin
    int c0, t, sum;
    logic [9:0] held;
    logic       mode;

    tbl[0]  = '{8'd10,  8'd3,   1'b0, 8'd7};
    tbl[1]  = '{8'd3,   8'd10,  1'b0, 8'd7};
    tbl[2]  = '{8'd200, 8'd55,  1'b0, 8'd145};
    tbl[3]  = '{8'd7,   8'd7,   1'b0, 8'd0};
    tbl[4]  = '{8'h7F,  8'h80,  1'b1, 8'd255};
    tbl[5]  = '{8'hFB,  8'h03,  1'b1, 8'd8};
    tbl[6]  = '{8'hFF,  8'hFF,  1'b1, 8'd0};
    tbl[7]  = '{8'h80,  8'h7F,  1'b1, 8'd255};
    tbl[8]  = '{8'd255, 8'd0,   1'b0, 8'd255};
    tbl[9]  = '{8'd0,   8'd255, 1'b0, 8'd255};
    tbl[10] = '{8'd1,   8'd2,   1'b0, 8'd1};
    tbl[11] = '{8'd128, 8'd127, 1'b0, 8'd1};
    tbl[12] = '{8'h80,  8'h80,  1'b1, 8'd0};
    tbl[13] = '{8'hFF,  8'h01,  1'b1, 8'd2};
    tbl[14] = '{8'h05,  8'hFE,  1'b1, 8'd7};
    tbl[15] = '{8'h81,  8'h7F,  1'b1, 8'd254};

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Ain = '0; Bin = '0; signed_mode = 1'b0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_diff_valid", 32'(diff_valid), 32'd0);

    // Table blocks, back-to-back samples
    for (int blk = 0; blk < 4; blk++) begin
      sum = 0;
      c0 = 0;
      for (int k = 0; k < 4; k++) begin
        send(tbl[4*blk+k].a, tbl[4*blk+k].b, tbl[4*blk+k].m, tbl[4*blk+k].d, t);
        if (k == 0) c0 = t;
        sum += int'(tbl[4*blk+k].d);
        if (k < 3) chk("out_valid_early", 32'(out_valid), 32'd0);
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("latency", 32'(cyc - c0), 32'd12);
      chk("sum", 32'(Sum), 32'(sum));
      if (blk != 3) handshake();
    end

    // DONE hold with in_valid asserted and no out_ready
    held = Sum;
    in_valid = 1'b1; Ain = 8'd9; Bin = 8'd1; signed_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_sum", 32'(Sum), 32'(held));
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_diff_valid", 32'(diff_valid), 32'd0);
    end
    in_valid = 1'b0;
    handshake();

    // Mid-block reset discards the partial block
    send(8'd50, 8'd0, 1'b0, 8'd50, t);
    send(8'd50, 8'd0, 1'b0, 8'd50, t);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_sum", 32'(Sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_diff", 32'(Diff), 32'd0);
    for (int k = 0; k < 4; k++) send(8'd1, 8'd0, 1'b0, 8'd1, t);
    chk("midrst_out_valid", 32'(out_valid), 32'd1);
    chk("midrst_final_sum", 32'(Sum), 32'd4);
    handshake();

    // Mode latched on the first sample only
    send(8'h80, 8'h01, 1'b0, 8'd127, t);
    send(8'h80, 8'h01, 1'b1, 8'd127, t);
    send(8'hFF, 8'h00, 1'b1, 8'd255, t);
    send(8'h00, 8'h90, 1'b1, 8'd144, t);
    chk("mode_latch_sum", 32'(Sum), 32'd653);
    handshake();

    // Random gaps, random operands, per-block reference sum
    for (int blk = 0; blk < 100; blk++) begin
      logic [7:0] a, b;
      mode = 1'($urandom);
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        int gap;
        gap = int'($urandom_range(2, 5));
        for (int g = 0; g < gap; g++) begin
          Ain = 8'($urandom); Bin = 8'($urandom); signed_mode = 1'($urandom);
          tick();
        end
        a = 8'($urandom);
        b = 8'($urandom);
        send(a, b, (k == 0) ? mode : 1'($urandom), ref_abs(a, b, mode), t);
        sum += int'(ref_abs(a, b, mode));
      end
      chk("rand_out_valid", 32'(out_valid), 32'd1);
      chk("rand_sum", 32'(Sum), 32'(sum));
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
